// File: rtl/usb_tx_arbiter_if.sv
// Requester-side bus of the usb_tx arbiter: per-source request/byte lanes in,
// per-source grant/accept/drop indications back.
interface usb_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   reqIsLast;
  logic [NUM_REQ-1:0]   reqDataValid;
  logic [NUM_REQ*8-1:0] reqData;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   reqAcceptNewData;
  logic [NUM_REQ-1:0]   dropped;

  modport master (
    output req, reqIsLast, reqDataValid, reqData,
    input  grant, reqAcceptNewData, dropped
  );

  modport slave (
    input  req, reqIsLast, reqDataValid, reqData,
    output grant, reqAcceptNewData, dropped
  );
endinterface

// File: rtl/usb_tx_arbiter.sv
// Fixed-priority arbiter sharing usb_tx between packet sources; owns outEN and
// only lets a packet out inside the turnaround window after a received EOP.
module usb_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int IPG_CYCLES   = 8,
  parameter int RESP_TIMEOUT = 30
) (
  input  logic                 clk48,
  input  logic                 rst_n,
  input  logic                 usbResetDetect,
  input  logic                 rxEop,
  usb_tx_arbiter_if.slave      reqBus,
  output logic                 txDone,
  output logic                 outEN,
  output logic                 reqSendPacket,
  output logic                 txIsLastByte,
  output logic                 txDataValid,
  output logic [7:0]           txData,
  input  logic                 txAcceptNewData,
  input  logic                 isSending
);

  localparam int GAP_W = $clog2(RESP_TIMEOUT + 2);
  localparam logic [GAP_W-1:0] GAP_CLOSED = GAP_W'(RESP_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_OPEN   = GAP_W'(IPG_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(RESP_TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, SEND, DRAIN} state_t;

  state_t             state;
  logic [GAP_W-1:0]   gapCnt;
  logic               seenSending;
  logic [NUM_REQ-1:0] grantR;
  logic [NUM_REQ-1:0] droppedR;
  logic               windowOpen;
  logic               lastAccepted;

  function automatic logic [NUM_REQ-1:0] lowestOne(input logic [NUM_REQ-1:0] v);
    return v & (~v + NUM_REQ'(1));
  endfunction

  assign windowOpen   = (gapCnt >= GAP_OPEN) && (gapCnt <= GAP_LAST);
  assign lastAccepted = txDataValid && txIsLastByte && txAcceptNewData;

  assign reqBus.grant            = grantR;
  assign reqBus.dropped          = droppedR;
  assign reqBus.reqAcceptNewData = grantR & {NUM_REQ{txAcceptNewData}};

  // Byte lane mux; grant is one-hot so at most one lane ever matches.
  always_comb begin
    txData       = '0;
    txDataValid  = 1'b0;
    txIsLastByte = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantR[i]) begin
        txData       = reqBus.reqData[i*8 +: 8];
        txDataValid  = reqBus.reqDataValid[i];
        txIsLastByte = reqBus.reqIsLast[i];
      end
    end
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      gapCnt        <= GAP_CLOSED;
      seenSending   <= 1'b0;
      grantR        <= '0;
      droppedR      <= '0;
      txDone        <= 1'b0;
      outEN         <= 1'b0;
      reqSendPacket <= 1'b0;
    end else if (usbResetDetect) begin
      state         <= IDLE;
      gapCnt        <= GAP_CLOSED;
      seenSending   <= 1'b0;
      grantR        <= '0;
      droppedR      <= '0;
      txDone        <= 1'b0;
      outEN         <= 1'b0;
      reqSendPacket <= 1'b0;
    end else begin
      droppedR      <= '0;
      txDone        <= 1'b0;
      reqSendPacket <= 1'b0;
      if (rxEop)
        gapCnt <= '0;
      else if (gapCnt != GAP_CLOSED)
        gapCnt <= gapCnt + GAP_W'(1);

      case (state)
        IDLE: begin
          if (|reqBus.req) begin
            if (windowOpen) begin
              grantR        <= lowestOne(reqBus.req);
              outEN         <= 1'b1;
              reqSendPacket <= 1'b1;
              state         <= START;
            end else if (gapCnt == GAP_CLOSED) begin
              // Masked by last cycle's pulse so a registered requester sees one pulse.
              droppedR <= reqBus.req & ~droppedR;
            end
          end
        end
        START: begin
          seenSending <= 1'b0;
          state       <= SEND;
        end
        SEND: begin
          if (isSending)
            seenSending <= 1'b1;
          if (lastAccepted)
            state <= DRAIN;
        end
        DRAIN: begin
          if (isSending) begin
            seenSending <= 1'b1;
          end else if (seenSending) begin
            // One response per received packet: close the window behind us.
            state  <= IDLE;
            outEN  <= 1'b0;
            grantR <= '0;
            txDone <= 1'b1;
            gapCnt <= GAP_CLOSED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Directed bench for usb_tx_arbiter: cycle table for a full packet plus
// hand-written sequences for priority, timeout, bus reset and async reset.
module tb_usb_tx_arbiter;

  logic       clk48 = 1'b0;
  logic       rst_n;
  logic       usbResetDetect;
  logic       rxEop;
  logic       txAcceptNewData;
  logic       isSending;
  logic       txDone;
  logic       outEN;
  logic       reqSendPacket;
  logic       txIsLastByte;
  logic       txDataValid;
  logic [7:0] txData;

  int checks = 0;
  int errors = 0;

  always #10 clk48 = ~clk48;

  usb_tx_arbiter_if #(.NUM_REQ(2)) bus();

  usb_tx_arbiter #(.NUM_REQ(2), .IPG_CYCLES(8), .RESP_TIMEOUT(30)) dut (
    .clk48          (clk48),
    .rst_n          (rst_n),
    .usbResetDetect (usbResetDetect),
    .rxEop          (rxEop),
    .reqBus         (bus.slave),
    .txDone         (txDone),
    .outEN          (outEN),
    .reqSendPacket  (reqSendPacket),
    .txIsLastByte   (txIsLastByte),
    .txDataValid    (txDataValid),
    .txData         (txData),
    .txAcceptNewData(txAcceptNewData),
    .isSending      (isSending)
  );

  typedef struct {
    logic       rxEop;
    logic [1:0] req;
    logic [1:0] vld;
    logic [1:0] last;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       acc;
    logic       snd;
    logic [1:0] eGrant;
    logic       eOutEN;
    logic       eSendPkt;
    logic       eTxDone;
    logic [1:0] eDrop;
    logic       eTxValid;
    logic       eTxLast;
    logic [7:0] eTxData;
    logic [1:0] eReqAcc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk2(input string nm, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk48);
    #1;
  endtask

  task automatic drive(input logic e, input logic [1:0] rq, input logic [1:0] vl,
                       input logic [1:0] ls, input logic [7:0] d0, input logic [7:0] d1,
                       input logic ac, input logic sn, input logic ur);
    rxEop            = e;
    bus.req          = rq;
    bus.reqDataValid = vl;
    bus.reqIsLast    = ls;
    bus.reqData      = {d1, d0};
    txAcceptNewData  = ac;
    isSending        = sn;
    usbResetDetect   = ur;
  endtask

  task automatic addV(input logic e, input logic [1:0] rq, input logic [1:0] vl,
                      input logic [1:0] ls, input logic [7:0] d0, input logic [7:0] d1,
                      input logic ac, input logic sn,
                      input logic [1:0] eg, input logic eo, input logic es, input logic et,
                      input logic [1:0] ed, input logic ev, input logic el,
                      input logic [7:0] edt, input logic [1:0] era);
    vec_t v;
    v.rxEop = e;  v.req = rq;  v.vld = vl;  v.last = ls;  v.d0 = d0;  v.d1 = d1;
    v.acc = ac;   v.snd = sn;
    v.eGrant = eg;  v.eOutEN = eo;  v.eSendPkt = es;  v.eTxDone = et;  v.eDrop = ed;
    v.eTxValid = ev;  v.eTxLast = el;  v.eTxData = edt;  v.eReqAcc = era;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic e, r0, r1, ac, sn, ur;

    // rxEop at c0, requester 1 from c2, 3-byte packet A5 01 02, then drain.
    addV(1'b1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00);
    addV(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00);
    for (int c = 2; c <= 9; c++)
      addV(1'b0, 2'b10, 2'b10, 2'b00, 8'h00, 8'hA5, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00);
    addV(1'b0, 2'b10, 2'b10, 2'b00, 8'h00, 8'hA5, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 8'hA5, 2'b00);
    addV(1'b0, 2'b10, 2'b10, 2'b00, 8'h00, 8'hA5, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'hA5, 2'b00);
    addV(1'b0, 2'b10, 2'b10, 2'b00, 8'h00, 8'hA5, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'hA5, 2'b10);
    addV(1'b0, 2'b10, 2'b10, 2'b00, 8'h00, 8'h01, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h01, 2'b00);
    addV(1'b0, 2'b10, 2'b10, 2'b00, 8'h00, 8'h01, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h01, 2'b10);
    addV(1'b0, 2'b10, 2'b10, 2'b10, 8'h00, 8'h02, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 8'h02, 2'b00);
    addV(1'b0, 2'b10, 2'b10, 2'b10, 8'h00, 8'h02, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 8'h02, 2'b10);
    addV(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00);
    addV(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00);
    addV(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00);
    addV(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00);
    addV(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00);

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk48);
    @(negedge clk48);
    rst_n = 1'b1;
    @(negedge clk48);
    chk2("reset grant", bus.grant, 2'b00);
    chk2("reset dropped", bus.dropped, 2'b00);
    chk1("reset outEN", outEN, 1'b0);
    chk1("reset reqSendPacket", reqSendPacket, 1'b0);
    chk1("reset txDone", txDone, 1'b0);
    chk1("reset txDataValid", txDataValid, 1'b0);

    // Table: single packet from requester 1
    for (int i = 0; i < vecs.size(); i++) begin
      tick();
      drive(vecs[i].rxEop, vecs[i].req, vecs[i].vld, vecs[i].last, vecs[i].d0, vecs[i].d1,
            vecs[i].acc, vecs[i].snd, 1'b0);
      @(negedge clk48);
      chk2($sformatf("A c%0d grant", i), bus.grant, vecs[i].eGrant);
      chk1($sformatf("A c%0d outEN", i), outEN, vecs[i].eOutEN);
      chk1($sformatf("A c%0d reqSendPacket", i), reqSendPacket, vecs[i].eSendPkt);
      chk1($sformatf("A c%0d txDone", i), txDone, vecs[i].eTxDone);
      chk2($sformatf("A c%0d dropped", i), bus.dropped, vecs[i].eDrop);
      chk1($sformatf("A c%0d txDataValid", i), txDataValid, vecs[i].eTxValid);
      chk1($sformatf("A c%0d txIsLastByte", i), txIsLastByte, vecs[i].eTxLast);
      chk8($sformatf("A c%0d txData", i), txData, vecs[i].eTxData);
      chk2($sformatf("A c%0d reqAccept", i), bus.reqAcceptNewData, vecs[i].eReqAcc);
    end

    // Both request in window: requester 0 wins, requester 1 dropped after txDone
    for (int k = 0; k <= 17; k++) begin
      tick();
      e = (k == 0);  r0 = (k >= 2 && k <= 11);  r1 = (k >= 2 && k <= 15);
      ac = (k == 11);  sn = (k == 11 || k == 12);
      drive(e, {r1, r0}, {r1, r0}, {1'b0, r0}, 8'hD2, 8'h77, ac, sn, 1'b0);
      @(negedge clk48);
      chk2($sformatf("B k%0d grant", k), bus.grant, (k >= 10 && k <= 13) ? 2'b01 : 2'b00);
      chk1($sformatf("B k%0d outEN", k), outEN, (k >= 10 && k <= 13));
      chk1($sformatf("B k%0d txDone", k), txDone, (k == 14));
      chk2($sformatf("B k%0d dropped", k), bus.dropped, (k == 15) ? 2'b10 : 2'b00);
      if (k == 10) chk1("B reqSendPacket", reqSendPacket, 1'b1);
      if (k == 11) begin
        chk8("B txData", txData, 8'hD2);
        chk2("B reqAccept", bus.reqAcceptNewData, 2'b01);
      end
    end

    // Window expired: request first raised at gapCnt == RESP_TIMEOUT+1
    for (int k = 0; k <= 35; k++) begin
      tick();
      r0 = (k == 32 || k == 33);
      drive(k == 0, {1'b0, r0}, {1'b0, r0}, {1'b0, r0}, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk48);
      chk1($sformatf("C k%0d outEN", k), outEN, 1'b0);
      chk2($sformatf("C k%0d grant", k), bus.grant, 2'b00);
      chk2($sformatf("C k%0d dropped", k), bus.dropped, (k == 33) ? 2'b01 : 2'b00);
    end

    // Last open gapCnt grants; usbResetDetect aborts during the second byte
    for (int k = 0; k <= 40; k++) begin
      tick();
      r1 = (k >= 31 && k <= 36);  r0 = (k == 38 || k == 39);
      ac = (k == 33);  sn = (k == 33 || k == 34);  ur = (k == 34);
      drive(k == 0, {r1, r0}, {r1, r0}, 2'b00, 8'h00, (k <= 33) ? 8'h11 : 8'h22, ac, sn, ur);
      @(negedge clk48);
      if (k >= 30) begin
        chk2($sformatf("E k%0d grant", k), bus.grant, (k >= 32 && k <= 34) ? 2'b10 : 2'b00);
        chk1($sformatf("E k%0d outEN", k), outEN, (k >= 32 && k <= 34));
        chk1($sformatf("E k%0d txDone", k), txDone, 1'b0);
        chk1($sformatf("E k%0d txDataValid", k), txDataValid, (k >= 32 && k <= 34));
        chk2($sformatf("E k%0d dropped", k), bus.dropped,
             (k == 36) ? 2'b10 : ((k == 39) ? 2'b01 : 2'b00));
      end
      if (k == 32) chk1("E reqSendPacket", reqSendPacket, 1'b1);
      if (k == 34) chk8("E txData byte2", txData, 8'h22);
    end

    // Async reset in DRAIN, then a request without rxEop is dropped
    for (int k = 0; k <= 16; k++) begin
      tick();
      r0 = (k >= 2 && k <= 11);  r1 = (k >= 14 && k <= 15);
      ac = (k == 11);  sn = (k == 11 || k == 12);
      drive(k == 0, {r1, r0}, {r1, r0}, {1'b0, r0}, 8'h5A, 8'h3C, ac, sn, 1'b0);
      @(negedge clk48);
      if (k == 10) chk1("F reqSendPacket", reqSendPacket, 1'b1);
      if (k == 12) begin
        chk2("F drain grant", bus.grant, 2'b01);
        chk1("F drain outEN", outEN, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk1("F async outEN", outEN, 1'b0);
        chk2("F async grant", bus.grant, 2'b00);
        chk1("F async reqSendPacket", reqSendPacket, 1'b0);
        chk1("F async txDataValid", txDataValid, 1'b0);
      end
      if (k == 13) rst_n = 1'b1;
      if (k == 14) chk2("F k14 dropped", bus.dropped, 2'b00);
      if (k == 15) begin
        chk2("F k15 dropped", bus.dropped, 2'b10);
        chk2("F k15 grant", bus.grant, 2'b00);
        chk1("F k15 outEN", outEN, 1'b0);
      end
      if (k == 16) chk2("F k16 dropped", bus.dropped, 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
